// File: rtl/multi_dim_packer_pkg.sv
// Shared types for the lane packer: FSM state encoding and count-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package multi_dim_packer_pkg;

  // FILL assembles a word; HOLD presents it to the consumer.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Width needed to count 0..n lanes; used for both the lane index and out_cnt.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_dim_packer.sv
// Packs LANE_W-bit lanes into LANES-lane words; in_last closes a word early, unused lanes read zero.
// Latency: out_valid rises one cycle after the closing lane is accepted; one lane/cycle sustained.
// Backpressure: in_ready=1 while filling, in_ready=out_ready while a word is held (next word may start on its transfer).
// Optional: define MULTI_DIM_PACKER_PARITY_EN to add out_par (per-lane XOR, registered with out_data).
module multi_dim_packer
  import multi_dim_packer_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANE_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [LANES*LANE_W-1:0]    out_data,
  output logic [cnt_w(LANES)-1:0]    out_cnt,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef MULTI_DIM_PACKER_PARITY_EN
  ,
  output logic [LANES-1:0]           out_par
`endif
);

  localparam int CW = cnt_w(LANES);

  state_t                          r_state;
  logic [CW-1:0]                   r_idx;
  logic [CW-1:0]                   r_cnt;
  logic                            r_vld;
  logic [LANES-1:0][LANE_W-1:0]    r_lanes;
`ifdef MULTI_DIM_PACKER_PARITY_EN
  logic [LANES-1:0]                r_par;
`endif

  // A held word frees its slot in the same cycle it transfers, so input readiness follows out_ready.
  assign in_ready  = (r_state == FILL) ? 1'b1 : out_ready;
  assign out_data  = r_lanes;
  assign out_cnt   = r_cnt;
  assign out_valid = r_vld;
`ifdef MULTI_DIM_PACKER_PARITY_EN
  assign out_par   = r_par;
`endif

  // Packer FSM: lane writes, word close, and hand-off of the held word with optional restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_lanes <= '0;
`ifdef MULTI_DIM_PACKER_PARITY_EN
      r_par   <= '0;
`endif
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
              if (r_idx == CW'(k)) begin
                r_lanes[k] <= in_data;
`ifdef MULTI_DIM_PACKER_PARITY_EN
                r_par[k]   <= ^in_data;
`endif
              end
            end
            if ((r_idx == CW'(LANES - 1)) || in_last) begin
              r_state <= HOLD;
              r_vld   <= 1'b1;
              r_cnt   <= r_idx + CW'(1);
            end else begin
              r_idx   <= r_idx + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            // Word leaves: clear storage so unwritten lanes of the next word read zero.
            r_state <= FILL;
            r_vld   <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_lanes <= '0;
`ifdef MULTI_DIM_PACKER_PARITY_EN
            r_par   <= '0;
`endif
            if (in_valid) begin
              // Simultaneous accept becomes lane 0 of the next word.
              r_lanes[0] <= in_data;
`ifdef MULTI_DIM_PACKER_PARITY_EN
              r_par[0]   <= ^in_data;
`endif
              if ((LANES == 1) || in_last) begin
                r_state <= HOLD;
                r_vld   <= 1'b1;
                r_cnt   <= CW'(1);
              end else begin
                r_idx   <= CW'(1);
              end
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dim_packer.sv
// Self-checking bench for multi_dim_packer (LANES=2, LANE_W=4).
// Expected words are queued as lanes are offered and compared when the word transfers.
// Define MULTI_DIM_PACKER_PARITY_EN to also check out_par.
module tb_multi_dim_packer;

  localparam int LANE_W = 4;
  localparam int LANES  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic [1:0] out_cnt;
  logic       out_valid;
  logic       out_ready;
`ifdef MULTI_DIM_PACKER_PARITY_EN
  logic [1:0] out_par;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rnd_ordy = 1'b0;

  always #5 clk = ~clk;

  multi_dim_packer #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MULTI_DIM_PACKER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  // Scoreboard: every output transfer is compared against the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h cnt=%0d, none expected", out_data, out_cnt);
      end else begin
        e = q.pop_front();
        if (out_data !== e.d || out_cnt !== e.c) begin
          errors++;
          $display("FAIL word: got data=%h cnt=%0d, expected data=%h cnt=%0d",
                   out_data, out_cnt, e.d, e.c);
        end
`ifdef MULTI_DIM_PACKER_PARITY_EN
        checks++;
        if (out_par !== {^e.d[7:4], ^e.d[3:0]}) begin
          errors++;
          $display("FAIL parity: got %b, expected %b", out_par, {^e.d[7:4], ^e.d[3:0]});
        end
`endif
      end
    end
  end

  // Random consumer backpressure during the random test.
  always @(posedge clk) begin
    if (rnd_ordy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Offer one lane until accepted; returns the number of cycles taken.
  task automatic put(input logic [3:0] d, input logic last, output int n);
    bit ok;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: lane %h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", out_cnt); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_full_word();
    int n;
    out_ready = 1'b1;
    q.push_back('{d: 8'hA3, c: 2'd2});
    put(4'h3, 1'b0, n);
    put(4'hA, 1'b0, n);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: out_valid=%b expected 1", out_valid); end
    if (out_data !== 8'hA3) begin errors++; $display("FAIL full_data: got %h expected a3", out_data); end
    if (out_cnt !== 2'd2) begin errors++; $display("FAIL full_cnt: got %0d expected 2", out_cnt); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_release: out_valid=%b expected 0", out_valid); end
    wait_drain();
  endtask

  task automatic test_last();
    int n;
    out_ready = 1'b1;
    // in_last without in_valid must not close anything
    in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL last_ignored: out_valid=%b expected 0", out_valid); end
    q.push_back('{d: 8'h05, c: 2'd1});
    put(4'h5, 1'b1, n);
    checks += 2;
    if (out_data !== 8'h05) begin errors++; $display("FAIL last_data: got %h expected 05", out_data); end
    if (out_cnt !== 2'd1) begin errors++; $display("FAIL last_cnt: got %0d expected 1", out_cnt); end
    wait_drain();
  endtask

  task automatic test_hold();
    int n;
    out_ready = 1'b0;
    q.push_back('{d: 8'h96, c: 2'd2});
    put(4'h6, 1'b0, n);
    put(4'h9, 1'b0, n);
    in_data  = 4'hF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, in_ready); end
      if (out_data !== 8'h96) begin errors++; $display("FAIL hold_data[%0d]: got %h expected 96", i, out_data); end
      if (out_cnt !== 2'd2) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 2", i, out_cnt); end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3, n4;
    out_ready = 1'b1;
    q.push_back('{d: 8'h21, c: 2'd2});
    q.push_back('{d: 8'h43, c: 2'd2});
    put(4'h1, 1'b0, n1);
    put(4'h2, 1'b0, n2);
    put(4'h3, 1'b0, n3);
    // 8'h21 transferred on the same edge that accepted 4'h3
    checks += 2;
    if (q.size() != 1) begin errors++; $display("FAIL b2b_overlap: pending=%0d expected 1", q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fill: out_valid=%b expected 0", out_valid); end
    put(4'h4, 1'b0, n4);
    checks += 2;
    if (n1 + n2 + n3 + n4 != 4) begin errors++; $display("FAIL b2b_rate: %0d cycles for 4 lanes expected 4", n1 + n2 + n3 + n4); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: out_valid=%b expected 1", out_valid); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    put(4'hF, 1'b0, n);
    rst = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", out_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back('{d: 8'h21, c: 2'd2});
    put(4'h1, 1'b0, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL post_rst_accept: took %0d cycles expected 1", n); end
    put(4'h2, 1'b0, n);
    wait_drain();
  endtask

  task automatic test_random();
    int         n;
    int         mi;
    logic [3:0] lo;
    logic [3:0] d;
    logic       last;
    mi = 0;
    lo = '0;
    rnd_ordy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      d    = 4'($urandom_range(0, 15));
      last = ($urandom_range(0, 3) == 0) || (i == 59);
      if (mi == 1) begin
        q.push_back('{d: {d, lo}, c: 2'd2});
        mi = 0;
      end else if (last) begin
        q.push_back('{d: {4'h0, d}, c: 2'd1});
      end else begin
        lo = d;
        mi = 1;
      end
      put(d, last, n);
    end
    rnd_ordy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
